// File: rtl/pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl
//
// Purpose:
//   Core-clock sequencer for a bank of NCH photonic-switch PWM generators.
//   The host writes per-channel A/B counter limits into shadow registers
//   through a valid/ready port. The block produces the frame-rate load strobe,
//   commits pending shadow values atomically at frame boundaries, and sequences
//   the per-channel enables through an OFF/ARM/RUN/STOP state machine.
//
// Ports:
//   clkCore       core clock, the only clock of this block
//   reset         synchronous, active-high reset
//   run_i         level request: 1 = run the PWM bank, 0 = stop it
//   ch_en_i       per-channel enable mask, sampled only at frame boundaries
//   wr_valid_i    host write valid
//   wr_ready_o    host write ready (high in every non-reset cycle)
//   wr_ch_i       target channel of a host write
//   wr_a_i        new A limit
//   wr_b_i        new B limit
//   A_val_o       active A limits, channel k at [k*W +: W]
//   B_val_o       active B limits, same packing
//   en_o          per-channel enable to the PWM generators
//   load_o        frame load strobe (high for the first half of each frame)
//   frame_tick_o  one-cycle pulse on every commit edge
//   pend_o        per-channel flag: shadow written but not yet committed
//   busy_o        state machine is not in OFF
//   wr_err_o      one-cycle pulse: a write to a channel >= NCH was dropped
// -----------------------------------------------------------------------------
module pwm_seq_ctrl #(
    parameter int unsigned W         = 7,
    parameter int unsigned NCH       = 4,
    parameter int unsigned CHW       = 2,
    parameter int unsigned FRAME_DIV = 200
) (
    input  logic               clkCore,
    input  logic               reset,
    input  logic               run_i,
    input  logic [NCH-1:0]     ch_en_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [CHW-1:0]     wr_ch_i,
    input  logic [W-1:0]       wr_a_i,
    input  logic [W-1:0]       wr_b_i,
    output logic [NCH*W-1:0]   A_val_o,
    output logic [NCH*W-1:0]   B_val_o,
    output logic [NCH-1:0]     en_o,
    output logic               load_o,
    output logic               frame_tick_o,
    output logic [NCH-1:0]     pend_o,
    output logic               busy_o,
    output logic               wr_err_o
);

    localparam int unsigned CNTW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAME_DIV - 1);
    localparam logic [CNTW-1:0] CNT_HALF = CNTW'(FRAME_DIV / 2);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [CNTW-1:0] frm_cnt_q, frm_cnt_d;
    logic [NCH-1:0]  en_q,      en_d;
    logic [NCH-1:0]  pend_q,    pend_d;
    logic            load_q,    load_d;
    logic            tick_q,    tick_d;
    logic            wr_err_q,  wr_err_d;

    logic [W-1:0] sh_a_q  [NCH];
    logic [W-1:0] sh_a_d  [NCH];
    logic [W-1:0] sh_b_q  [NCH];
    logic [W-1:0] sh_b_d  [NCH];
    logic [W-1:0] act_a_q [NCH];
    logic [W-1:0] act_a_d [NCH];
    logic [W-1:0] act_b_q [NCH];
    logic [W-1:0] act_b_d [NCH];

    logic wr_fire;
    logic ch_ok;
    logic boundary;
    logic commit;

    // Ready is simply "not in reset"; the shadow bank can always absorb a write.
    assign wr_ready_o = ~reset;

    always_comb begin
        wr_fire  = wr_valid_i & wr_ready_o;
        ch_ok    = (32'(wr_ch_i) < NCH);
        boundary = (state_q != ST_OFF) && (frm_cnt_q == CNT_LAST);

        state_d  = state_q;
        en_d     = en_q;
        commit   = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (run_i) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Dropping run while arming aborts at once, even on a boundary.
                if (!run_i) begin
                    state_d = ST_OFF;
                end else if (boundary) begin
                    commit  = 1'b1;
                    en_d    = ch_en_i;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A boundary commit happens even if run drops in the same cycle.
                if (boundary) begin
                    commit = 1'b1;
                    en_d   = ch_en_i;
                end
                if (!run_i) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Re-raising run resumes the current frame; a boundary seen in
                // that same cycle is not a commit point (STOP never commits).
                if (run_i) begin
                    state_d = ST_RUN;
                end else if (boundary) begin
                    en_d    = '0;
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                en_d    = '0;
            end
        endcase

        // Counter is parked at 0 in OFF and starts from 0 on the cycle after
        // leaving OFF, so the first frame after run is a full frame.
        if ((state_d == ST_OFF) || (state_q == ST_OFF) || boundary) begin
            frm_cnt_d = '0;
        end else begin
            frm_cnt_d = frm_cnt_q + CNTW'(1);
        end

        // Registered from next-state values so load_o tracks the counter
        // that is visible in the same cycle; it rises on the commit edge.
        load_d   = (state_d != ST_OFF) && (frm_cnt_d < CNT_HALF);
        tick_d   = commit;
        wr_err_d = wr_fire & ~ch_ok;

        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        act_a_d = act_a_q;
        act_b_d = act_b_q;
        pend_d  = pend_q;

        // Commit uses the old shadow contents, so a write landing in the
        // boundary cycle stays pending until the following boundary.
        if (commit) begin
            for (int k = 0; k < NCH; k++) begin
                if (pend_q[k]) begin
                    act_a_d[k] = sh_a_q[k];
                    act_b_d[k] = sh_b_q[k];
                end
            end
            pend_d = '0;
        end

        if (wr_fire && ch_ok) begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_ch_i == CHW'(k)) begin
                    sh_a_d[k] = wr_a_i;
                    sh_b_d[k] = wr_b_i;
                    pend_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkCore) begin
        if (reset) begin
            state_q   <= ST_OFF;
            frm_cnt_q <= '0;
            en_q      <= '0;
            pend_q    <= '0;
            load_q    <= 1'b0;
            tick_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                sh_a_q[k]  <= '0;
                sh_b_q[k]  <= '0;
                act_a_q[k] <= '0;
                act_b_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            load_q    <= load_d;
            tick_q    <= tick_d;
            wr_err_q  <= wr_err_d;
            for (int k = 0; k < NCH; k++) begin
                sh_a_q[k]  <= sh_a_d[k];
                sh_b_q[k]  <= sh_b_d[k];
                act_a_q[k] <= act_a_d[k];
                act_b_q[k] <= act_b_d[k];
            end
        end
    end

    always_comb begin
        A_val_o = '0;
        B_val_o = '0;
        for (int k = 0; k < NCH; k++) begin
            A_val_o[k*W +: W] = act_a_q[k];
            B_val_o[k*W +: W] = act_b_q[k];
        end
    end

    assign en_o         = en_q;
    assign pend_o       = pend_q;
    assign load_o       = load_q;
    assign frame_tick_o = tick_q;
    assign wr_err_o     = wr_err_q;
    assign busy_o       = (state_q != ST_OFF);

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_seq_ctrl
//
// Bench for pwm_seq_ctrl with NCH=4 and a 3-bit channel index so that
// out-of-range writes can be issued. A frame-level reference model (pending
// write queue, frame position, run mode) is stepped every clock and compared
// against all outputs; a vector table and hand-written sequences add fixed
// expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_pwm_seq_ctrl;

    localparam int W   = 7;
    localparam int NCH = 4;
    localparam int CHW = 3;
    localparam int FD  = 200;

    logic             clk;
    logic             rst;
    logic             run;
    logic [NCH-1:0]   chen;
    logic             wv;
    logic             wr_ready;
    logic [CHW-1:0]   wch;
    logic [W-1:0]     wa;
    logic [W-1:0]     wb;
    logic [NCH*W-1:0] a_val;
    logic [NCH*W-1:0] b_val;
    logic [NCH-1:0]   en;
    logic             load;
    logic             tick;
    logic [NCH-1:0]   pend;
    logic             busy;
    logic             wr_err;

    pwm_seq_ctrl #(.W(W), .NCH(NCH), .CHW(CHW), .FRAME_DIV(FD)) dut (
        .clkCore     (clk),
        .reset       (rst),
        .run_i       (run),
        .ch_en_i     (chen),
        .wr_valid_i  (wv),
        .wr_ready_o  (wr_ready),
        .wr_ch_i     (wch),
        .wr_a_i      (wa),
        .wr_b_i      (wb),
        .A_val_o     (a_val),
        .B_val_o     (b_val),
        .en_o        (en),
        .load_o      (load),
        .frame_tick_o(tick),
        .pend_o      (pend),
        .busy_o      (busy),
        .wr_err_o    (wr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] get_a(input int k);
        return a_val[k*W +: W];
    endfunction

    function automatic logic [W-1:0] get_b(input int k);
        return b_val[k*W +: W];
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } wr_t;

    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_STOP = 3;

    wr_t            m_q[$];
    int             m_mode = M_OFF;
    int             m_pos  = 0;
    logic [W-1:0]   m_a[NCH];
    logic [W-1:0]   m_b[NCH];
    logic [NCH-1:0] m_en   = '0;
    bit             m_tick = 1'b0;
    bit             m_err  = 1'b0;

    // Advance the model by one clock using the inputs held before the edge.
    task automatic model_step();
        bit  at_edge;
        bit  do_commit;
        int  nxt;
        wr_t w;
        if (rst) begin
            m_mode = M_OFF;
            m_pos  = 0;
            m_q.delete();
            for (int k = 0; k < NCH; k++) begin
                m_a[k] = '0;
                m_b[k] = '0;
            end
            m_en   = '0;
            m_tick = 1'b0;
            m_err  = 1'b0;
            return;
        end
        at_edge   = (m_mode != M_OFF) && (m_pos == FD - 1);
        do_commit = 1'b0;
        nxt       = m_mode;
        m_err     = wv && (int'(wch) >= NCH);
        if (m_mode == M_OFF) begin
            if (run) nxt = M_ARM;
        end else if (m_mode == M_ARM) begin
            if (!run) nxt = M_OFF;
            else if (at_edge) begin
                do_commit = 1'b1;
                m_en      = chen;
                nxt       = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (at_edge) begin
                do_commit = 1'b1;
                m_en      = chen;
            end
            if (!run) nxt = M_STOP;
        end else begin
            if (run) nxt = M_RUN;
            else if (at_edge) begin
                m_en = '0;
                nxt  = M_OFF;
            end
        end
        if (do_commit) begin
            foreach (m_q[i]) begin
                m_a[int'(m_q[i].ch)] = m_q[i].a;
                m_b[int'(m_q[i].ch)] = m_q[i].b;
            end
            m_q.delete();
        end
        if (wv && (int'(wch) < NCH)) begin
            w.ch = wch;
            w.a  = wa;
            w.b  = wb;
            m_q.push_back(w);
        end
        m_tick = do_commit;
        if ((nxt == M_OFF) || (m_mode == M_OFF) || at_edge) m_pos = 0;
        else m_pos = m_pos + 1;
        m_mode = nxt;
    endtask

    task automatic model_compare();
        logic [NCH-1:0]   exp_pend;
        logic [NCH*W-1:0] exp_a;
        logic [NCH*W-1:0] exp_b;
        exp_pend = '0;
        foreach (m_q[i]) exp_pend[int'(m_q[i].ch)] = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            exp_a[k*W +: W] = m_a[k];
            exp_b[k*W +: W] = m_b[k];
        end
        chk("model.ready", 64'(wr_ready), 64'(!rst));
        chk("model.A_val", 64'(a_val), 64'(exp_a));
        chk("model.B_val", 64'(b_val), 64'(exp_b));
        chk("model.en", 64'(en), 64'(m_en));
        chk("model.pend", 64'(pend), 64'(exp_pend));
        chk("model.tick", 64'(tick), 64'(m_tick));
        chk("model.wr_err", 64'(wr_err), 64'(m_err));
        chk("model.busy", 64'(busy), 64'(m_mode != M_OFF));
        chk("model.load", 64'(load), 64'((m_mode != M_OFF) && (m_pos < FD / 2)));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            model_compare();
        end
    endtask

    task automatic drive(input bit r, input logic [NCH-1:0] ce, input bit v,
                         input logic [CHW-1:0] c, input logic [W-1:0] aa, input logic [W-1:0] bb);
        run  = r;
        chen = ce;
        wv   = v;
        wch  = c;
        wa   = aa;
        wb   = bb;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit             rst;
        bit             run;
        logic [NCH-1:0] chen;
        bit             wv;
        logic [CHW-1:0] ch;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             n;
        logic [NCH-1:0] e_en;
        logic [NCH-1:0] e_pend;
        bit             e_busy;
        bit             e_load;
        bit             e_tick;
        bit             e_err;
        logic [W-1:0]   e_a2;
        logic [W-1:0]   e_b2;
    } vec_t;

    function automatic vec_t mk(bit r, bit ru, logic [NCH-1:0] ce, bit v, logic [CHW-1:0] c,
                                logic [W-1:0] aa, logic [W-1:0] bb, int n,
                                logic [NCH-1:0] een, logic [NCH-1:0] epd, bit ebs, bit eld,
                                bit etk, bit eer, logic [W-1:0] ea2, logic [W-1:0] eb2);
        vec_t v_;
        v_.rst = r;    v_.run = ru;   v_.chen = ce;    v_.wv = v;
        v_.ch = c;     v_.a = aa;     v_.b = bb;       v_.n = n;
        v_.e_en = een; v_.e_pend = epd; v_.e_busy = ebs; v_.e_load = eld;
        v_.e_tick = etk; v_.e_err = eer; v_.e_a2 = ea2; v_.e_b2 = eb2;
        return v_;
    endfunction

    localparam int NV = 12;
    vec_t vt[NV];

    int ticks_seen;
    int en_seen;
    bit run_r;

    initial begin
        //             rst run chen  wv ch a   b   n    en    pend  bsy ld tk er a2  b2
        vt[0]  = mk(1, 1, 4'h0, 1, 2, 5,  6,  2,   4'h0, 4'h0, 0, 0, 0, 0, 0,  0);
        vt[1]  = mk(0, 0, 4'h0, 0, 0, 0,  0,  3,   4'h0, 4'h0, 0, 0, 0, 0, 0,  0);
        vt[2]  = mk(0, 0, 4'h0, 1, 2, 40, 60, 1,   4'h0, 4'h4, 0, 0, 0, 0, 0,  0);
        vt[3]  = mk(0, 0, 4'h0, 1, 5, 1,  1,  1,   4'h0, 4'h4, 0, 0, 0, 1, 0,  0);
        vt[4]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  1,   4'h0, 4'h4, 1, 1, 0, 0, 0,  0);
        vt[5]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  199, 4'h0, 4'h4, 1, 0, 0, 0, 0,  0);
        vt[6]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  1,   4'h5, 4'h0, 1, 1, 1, 0, 40, 60);
        vt[7]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  1,   4'h5, 4'h0, 1, 1, 0, 0, 40, 60);
        vt[8]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  98,  4'h5, 4'h0, 1, 1, 0, 0, 40, 60);
        vt[9]  = mk(0, 1, 4'h5, 0, 0, 0,  0,  1,   4'h5, 4'h0, 1, 0, 0, 0, 40, 60);
        vt[10] = mk(0, 1, 4'h5, 0, 0, 0,  0,  99,  4'h5, 4'h0, 1, 0, 0, 0, 40, 60);
        vt[11] = mk(0, 1, 4'h5, 0, 0, 0,  0,  1,   4'h5, 4'h0, 1, 1, 1, 0, 40, 60);

        rst = 1'b1;
        drive(1, 4'h0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst;
            drive(vt[i].run, vt[i].chen, vt[i].wv, vt[i].ch, vt[i].a, vt[i].b);
            step(vt[i].n);
            chk($sformatf("vec%0d.ready", i), 64'(wr_ready), 64'(!vt[i].rst));
            chk($sformatf("vec%0d.en", i), 64'(en), 64'(vt[i].e_en));
            chk($sformatf("vec%0d.pend", i), 64'(pend), 64'(vt[i].e_pend));
            chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(vt[i].e_busy));
            chk($sformatf("vec%0d.load", i), 64'(load), 64'(vt[i].e_load));
            chk($sformatf("vec%0d.tick", i), 64'(tick), 64'(vt[i].e_tick));
            chk($sformatf("vec%0d.wr_err", i), 64'(wr_err), 64'(vt[i].e_err));
            chk($sformatf("vec%0d.A2", i), 64'(get_a(2)), 64'(vt[i].e_a2));
            chk($sformatf("vec%0d.B2", i), 64'(get_b(2)), 64'(vt[i].e_b2));
        end

        // Last-write-wins in a frame, and a write in the boundary cycle
        // is deferred by one frame. Starts in RUN at frame position 0.
        drive(1, 4'h5, 1, 1, 10, 11); step(1);
        drive(1, 4'h5, 1, 1, 20, 21); step(1);
        drive(1, 4'h5, 0, 0, 0, 0);   step(197);
        drive(1, 4'h5, 1, 0, 7, 8);   step(1);
        chk("lww.A1", 64'(get_a(1)), 64'd20);
        chk("lww.B1", 64'(get_b(1)), 64'd21);
        chk("lww.A0_deferred", 64'(get_a(0)), 64'd0);
        chk("lww.pend", 64'(pend), 64'h1);
        chk("lww.tick", 64'(tick), 64'd1);
        drive(1, 4'h5, 0, 0, 0, 0);   step(199);
        chk("lww.A0_still_pending", 64'(get_a(0)), 64'd0);
        step(1);
        chk("lww.A0_commit", 64'(get_a(0)), 64'd7);
        chk("lww.B0_commit", 64'(get_b(0)), 64'd8);
        chk("lww.pend_clear", 64'(pend), 64'h0);

        // Stop mid-frame: enables hold to the boundary, pending write kept.
        drive(1, 4'h5, 1, 3, 9, 9);   step(1);
        drive(1, 4'h5, 0, 0, 0, 0);   step(49);
        drive(0, 4'hF, 0, 0, 0, 0);   step(1);
        chk("stop.en_hold", 64'(en), 64'h5);
        chk("stop.busy", 64'(busy), 64'd1);
        step(148);
        chk("stop.en_hold_late", 64'(en), 64'h5);
        step(1);
        chk("stop.en_off", 64'(en), 64'h0);
        chk("stop.busy_off", 64'(busy), 64'd0);
        chk("stop.load_off", 64'(load), 64'd0);
        chk("stop.no_tick", 64'(tick), 64'd0);
        chk("stop.pend_kept", 64'(pend), 64'h8);
        chk("stop.A3_uncommitted", 64'(get_a(3)), 64'd0);

        // Restart, then re-raise run while in STOP: no frame restart.
        drive(1, 4'hF, 0, 0, 0, 0);   step(1);
        step(199);
        chk("restart.en_not_yet", 64'(en), 64'h0);
        step(1);
        chk("restart.en", 64'(en), 64'hF);
        chk("restart.A3", 64'(get_a(3)), 64'd9);
        chk("restart.tick", 64'(tick), 64'd1);
        step(30);
        drive(0, 4'hF, 0, 0, 0, 0);   step(1);
        drive(1, 4'h3, 0, 0, 0, 0);   step(1);
        chk("resume.en", 64'(en), 64'hF);
        chk("resume.busy", 64'(busy), 64'd1);
        step(167);
        chk("resume.en_hold", 64'(en), 64'hF);
        chk("resume.no_early_tick", 64'(tick), 64'd0);
        step(1);
        chk("resume.tick_on_schedule", 64'(tick), 64'd1);
        chk("resume.en_new", 64'(en), 64'h3);

        // Short run pulse from OFF: ARM then OFF without any enable.
        drive(0, 4'h3, 0, 0, 0, 0);   step(200);
        chk("pulse.start_off", 64'(busy), 64'd0);
        drive(1, 4'hF, 0, 0, 0, 0);
        ticks_seen = 0;
        en_seen    = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick) ticks_seen++;
            if (en != '0) en_seen++;
        end
        drive(0, 4'hF, 0, 0, 0, 0);   step(1);
        chk("pulse.ticks", 64'(ticks_seen), 64'd0);
        chk("pulse.en_cycles", 64'(en_seen), 64'd0);
        chk("pulse.busy", 64'(busy), 64'd0);
        chk("pulse.load", 64'(load), 64'd0);

        // Randomised traffic against the model: slow then fast run toggling.
        run_r = 1'b1;
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, (i < 6000) ? 249 : 19) == 0) run_r = ~run_r;
            rst = ($urandom_range(0, 2999) == 0);
            drive(run_r, NCH'($urandom), ($urandom_range(0, 4) == 0),
                  CHW'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
